// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared SSD display codes, cathode glyph patterns and anode helpers
package ssd_pkg;

  localparam logic [4:0] CODE_OFF  = 5'b10000;
  localparam logic [4:0] CODE_Y    = 5'b10001;
  localparam logic [4:0] CODE_A_LC = 5'b10010;
  localparam logic [4:0] CODE_L    = 5'b10011;
  localparam logic [4:0] CODE_BAD  = 5'b11111;

  // Segment order is {a,b,c,d,e,f,g}, a segment is lit when its bit is 0.
  localparam logic [6:0] PAT_0    = 7'b0000001;
  localparam logic [6:0] PAT_1    = 7'b1001111;
  localparam logic [6:0] PAT_2    = 7'b0010010;
  localparam logic [6:0] PAT_3    = 7'b0000110;
  localparam logic [6:0] PAT_4    = 7'b1001100;
  localparam logic [6:0] PAT_5    = 7'b0100100;
  localparam logic [6:0] PAT_6    = 7'b0100000;
  localparam logic [6:0] PAT_7    = 7'b0001111;
  localparam logic [6:0] PAT_8    = 7'b0000000;
  localparam logic [6:0] PAT_9    = 7'b0000100;
  localparam logic [6:0] PAT_A    = 7'b0001000;
  localparam logic [6:0] PAT_B    = 7'b1100000;
  localparam logic [6:0] PAT_C    = 7'b0110001;
  localparam logic [6:0] PAT_D    = 7'b1000010;
  localparam logic [6:0] PAT_E    = 7'b0110000;
  localparam logic [6:0] PAT_F    = 7'b0111000;
  localparam logic [6:0] PAT_OFF  = 7'b1111111;
  localparam logic [6:0] PAT_Y    = 7'b1000100;
  localparam logic [6:0] PAT_A_LC = 7'b0000010;
  localparam logic [6:0] PAT_L    = 7'b1110001;

  typedef enum logic [1:0] {
    AN_BLANK,
    AN_SINGLE,
    AN_MULTI
  } an_class_e;

  function automatic an_class_e an_classify(input logic [7:0] an);
    logic [7:0] lo;
    lo = ~an;
    if (lo == 8'h00) return AN_BLANK;
    if ((lo & (lo - 8'd1)) == 8'h00) return AN_SINGLE;
    return AN_MULTI;
  endfunction

  function automatic logic [2:0] an_index(input logic [7:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ssd_glyph_decode.sv
// rtl/ssd_glyph_decode.sv - combinational cathode pattern to 5-bit display code
module ssd_glyph_decode
  import ssd_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [4:0] code,
  output logic       bad
);

  always_comb begin
    code = CODE_BAD;
    bad  = 1'b0;
    case (pattern)
      PAT_0:    code = 5'h00;
      PAT_1:    code = 5'h01;
      PAT_2:    code = 5'h02;
      PAT_3:    code = 5'h03;
      PAT_4:    code = 5'h04;
      PAT_5:    code = 5'h05;
      PAT_6:    code = 5'h06;
      PAT_7:    code = 5'h07;
      PAT_8:    code = 5'h08;
      PAT_9:    code = 5'h09;
      PAT_A:    code = 5'h0A;
      PAT_B:    code = 5'h0B;
      PAT_C:    code = 5'h0C;
      PAT_D:    code = 5'h0D;
      PAT_E:    code = 5'h0E;
      PAT_F:    code = 5'h0F;
      PAT_OFF:  code = CODE_OFF;
      PAT_Y:    code = CODE_Y;
      PAT_A_LC: code = CODE_A_LC;
      PAT_L:    code = CODE_L;
      default: begin
        code = CODE_BAD;
        bad  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// rtl/ssd_scan_decoder.sv - samples a scanned 8-digit SSD bus and reports decoded frames
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [7:0]  An,
  input  logic [7:0]  Cath,
  output logic [39:0] frame_codes,
  output logic [7:0]  frame_dp,
  output logic        frame_valid,
  output logic        an_err,
  output logic        glyph_err
);

  localparam int               CNT_W   = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(SETTLE_CYCLES - 1);
  localparam int               SYNC_W  = 16 * SYNC_STAGES;

  logic [SYNC_W-1:0] sync_q;
  logic [15:0]       nxt_s;
  logic [15:0]       cur_s;
  an_class_e         nxt_class;
  an_class_e         cur_class;
  logic              stable;
  logic              capture;
  logic [2:0]        idx;
  logic [4:0]        glyph_code;
  logic              glyph_bad;

  logic [CNT_W-1:0]  stable_cnt;
  logic              captured;
  logic [39:0]       digits_q;
  logic [7:0]        dp_q;
  logic [7:0]        seen_q;
  logic [39:0]       digits_nx;
  logic [7:0]        dp_nx;
  logic [7:0]        seen_nx;

  // The final sync stage doubles as the previous-cycle copy, so the value entering
  // it is compared against the value it currently holds.
  assign nxt_s     = sync_q[16*(SYNC_STAGES-2) +: 16];
  assign cur_s     = sync_q[16*(SYNC_STAGES-1) +: 16];
  assign nxt_class = an_classify(nxt_s[15:8]);
  assign cur_class = an_classify(cur_s[15:8]);
  assign stable    = (nxt_class == AN_SINGLE) && (nxt_s == cur_s);
  assign capture   = stable && !captured && (stable_cnt == CNT_CAP);
  assign idx       = an_index(cur_s[15:8]);

  ssd_glyph_decode u_glyph (
    .pattern (cur_s[7:1]),
    .code    (glyph_code),
    .bad     (glyph_bad)
  );

  always_comb begin
    digits_nx = digits_q;
    dp_nx     = dp_q;
    seen_nx   = seen_q | (8'd1 << idx);
    digits_nx[5*idx +: 5] = glyph_code;
    dp_nx[idx]            = ~cur_s[0];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q      <= '1;
      stable_cnt  <= '0;
      captured    <= 1'b0;
      digits_q    <= {8{CODE_OFF}};
      dp_q        <= 8'h00;
      seen_q      <= 8'h00;
      frame_codes <= {8{CODE_OFF}};
      frame_dp    <= 8'h00;
      frame_valid <= 1'b0;
      an_err      <= 1'b0;
      glyph_err   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_W-17:0], An, Cath};
      frame_valid <= 1'b0;
      glyph_err   <= 1'b0;
      an_err      <= (nxt_class == AN_MULTI) && (cur_class != AN_MULTI);

      if (stable) begin
        if (stable_cnt != CNT_MAX) stable_cnt <= stable_cnt + 1'b1;
      end else begin
        stable_cnt <= '0;
        captured   <= 1'b0;
      end

      if (capture) begin
        captured  <= 1'b1;
        digits_q  <= digits_nx;
        dp_q      <= dp_nx;
        glyph_err <= glyph_bad;
        // Frame completion uses the working set including this capture.
        if (seen_nx == 8'hFF) begin
          frame_codes <= digits_nx;
          frame_dp    <= dp_nx;
          frame_valid <= 1'b1;
          seen_q      <= 8'h00;
        end else begin
          seen_q <= seen_nx;
        end
      end
    end
  end

endmodule
